// File: rtl/codificador_estado.sv
// Push-button to 2-bit state-code encoder: 2-flop sync, debounce, one-hot check, registered commit.
// Define CODIFICADOR_SEQ_TRAVADA_EN to accept only the legal successor of the current code.
module codificador_estado #(
  parameter int DEBOUNCE_CYCLES = 1000,
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       botao_00,
  input  logic       botao_01,
  input  logic       botao_10,
  output logic [1:0] estado,
  output logic       novo_estado,
  output logic       erro,
  output logic       ocupado,
  output logic [1:0] fsm_estado
);

  typedef enum logic [1:0] {
    OCIOSO        = 2'd0,
    FILTRANDO     = 2'd1,
    CONFIRMA      = 2'd2,
    ESPERA_SOLTAR = 2'd3
  } fsm_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  fsm_t             state, state_nx;
  logic [2:0]       sync_a, sync_b;
  logic [2:0]       s;
  logic [2:0]       amostra, amostra_nx;
  logic [CNT_W-1:0] contador, contador_nx;
  logic [1:0]       estado_nx;
  logic             novo_nx, erro_nx;
  logic [1:0]       codigo;
  logic             one_hot;
  logic [1:0]       sucessor;
  logic             pedido_ok;

  // Raw buttons are asynchronous; only sync_b is ever looked at by the FSM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_a <= 3'b000;
      sync_b <= 3'b000;
    end else begin
      sync_a <= {botao_10, botao_01, botao_00};
      sync_b <= sync_a;
    end
  end

  assign s = sync_b;

  always_comb begin
    codigo  = 2'b00;
    one_hot = 1'b0;
    case (amostra)
      3'b001: begin codigo = 2'b00; one_hot = 1'b1; end
      3'b010: begin codigo = 2'b01; one_hot = 1'b1; end
      3'b100: begin codigo = 2'b10; one_hot = 1'b1; end
      default: begin codigo = 2'b00; one_hot = 1'b0; end
    endcase
  end

  always_comb begin
    case (estado)
      2'b00:   sucessor = 2'b01;
      2'b01:   sucessor = 2'b10;
      default: sucessor = 2'b00;
    endcase
  end

`ifdef CODIFICADOR_SEQ_TRAVADA_EN
  assign pedido_ok = one_hot && (codigo == sucessor);
`else
  assign pedido_ok = one_hot;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= OCIOSO;
      amostra     <= 3'b000;
      contador    <= '0;
      estado      <= 2'b00;
      novo_estado <= 1'b0;
      erro        <= 1'b0;
    end else begin
      state       <= state_nx;
      amostra     <= amostra_nx;
      contador    <= contador_nx;
      estado      <= estado_nx;
      novo_estado <= novo_nx;
      erro        <= erro_nx;
    end
  end

  // Strobes default low so each one lasts exactly the cycle after CONFIRMA.
  always_comb begin
    state_nx    = state;
    amostra_nx  = amostra;
    contador_nx = contador;
    estado_nx   = estado;
    novo_nx     = 1'b0;
    erro_nx     = 1'b0;
    case (state)
      OCIOSO: begin
        if (s != 3'b000) begin
          amostra_nx  = s;
          contador_nx = '0;
          state_nx    = FILTRANDO;
        end
      end
      FILTRANDO: begin
        if (s != amostra) begin
          state_nx = OCIOSO;
        end else if (contador == CNT_MAX) begin
          state_nx = CONFIRMA;
        end else begin
          contador_nx = contador + CNT_ONE;
        end
      end
      CONFIRMA: begin
        if (pedido_ok) begin
          estado_nx = codigo;
          novo_nx   = 1'b1;
        end else begin
          erro_nx = 1'b1;
        end
        contador_nx = '0;
        state_nx    = ESPERA_SOLTAR;
      end
      ESPERA_SOLTAR: begin
        // Any activity while waiting for release only restarts the timer.
        if (s != 3'b000) begin
          contador_nx = '0;
        end else if (contador == CNT_MAX) begin
          state_nx = OCIOSO;
        end else begin
          contador_nx = contador + CNT_ONE;
        end
      end
      default: state_nx = OCIOSO;
    endcase
  end

  assign ocupado    = (state != OCIOSO);
  assign fsm_estado = state;

endmodule

// File: tb/tb_codificador_estado.sv
// Bench for codificador_estado with DEBOUNCE_CYCLES=4; strobes are checked against queued expectations.
module tb_codificador_estado;
  localparam int D = 4;
  localparam int LAT = D + 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       botao_00 = 1'b0, botao_01 = 1'b0, botao_10 = 1'b0;
  logic [1:0] estado, fsm_estado;
  logic       novo_estado, erro, ocupado;

  int errors = 0;
  int checks = 0;
  int n_novo = 0;
  int n_erro = 0;
  logic [1:0] exp_q[$];
  logic [1:0] err_q[$];
  logic [1:0] est_model = 2'b00;
  logic [1:0] mon_e;

  always #5 clock = ~clock;

  codificador_estado #(.DEBOUNCE_CYCLES(D)) dut (
    .clock(clock), .reset(reset),
    .botao_00(botao_00), .botao_01(botao_01), .botao_10(botao_10),
    .estado(estado), .novo_estado(novo_estado), .erro(erro),
    .ocupado(ocupado), .fsm_estado(fsm_estado)
  );

  // Scoreboard: every strobe must match the oldest queued expectation.
  always @(negedge clock) begin
    if (reset) begin
      if (novo_estado || erro) begin
        checks++;
        if (novo_estado && erro) begin
          errors++; $display("FAIL strobe_overlap novo=%b erro=%b required not both", novo_estado, erro);
        end
      end
      if (novo_estado) begin
        n_novo++; checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL unexpected_novo estado=%b required no strobe", estado);
        end else begin
          mon_e = exp_q.pop_front();
          if (estado !== mon_e) begin
            errors++; $display("FAIL novo_code estado=%b required %b", estado, mon_e);
          end
        end
      end
      if (erro) begin
        n_erro++; checks++;
        if (err_q.size() == 0) begin
          errors++; $display("FAIL unexpected_erro estado=%b required no erro", estado);
        end else begin
          mon_e = err_q.pop_front();
          if (estado !== mon_e) begin
            errors++; $display("FAIL erro_hold estado=%b required %b", estado, mon_e);
          end
        end
      end
    end
  end

  function automatic void expect_press(input logic [2:0] mask);
    logic [1:0] cod;
    logic       oh;
    logic [1:0] suc;
    oh  = (mask == 3'b001) || (mask == 3'b010) || (mask == 3'b100);
    cod = (mask == 3'b010) ? 2'b01 : (mask == 3'b100) ? 2'b10 : 2'b00;
    suc = (est_model == 2'b00) ? 2'b01 : (est_model == 2'b01) ? 2'b10 : 2'b00;
`ifdef CODIFICADOR_SEQ_TRAVADA_EN
    oh = oh && (cod == suc);
`else
    if (suc == cod) oh = oh;
`endif
    if (oh) begin
      exp_q.push_back(cod);
      est_model = cod;
    end else begin
      err_q.push_back(est_model);
    end
  endfunction

  task automatic set_botoes(input logic [2:0] mask);
    botao_00 = mask[0];
    botao_01 = mask[1];
    botao_10 = mask[2];
  endtask

  task automatic wait_idle(input string nome);
    int n;
    n = 0;
    while (ocupado && n < 60) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (ocupado !== 1'b0) begin
      errors++; $display("FAIL %s_idle_timeout ocupado=%b required 0 within 60 cycles", nome, ocupado);
    end
  endtask

  task automatic press(input logic [2:0] mask, input int hold, input string nome);
    set_botoes(mask);
    expect_press(mask);
    repeat (hold) @(negedge clock);
    set_botoes(3'b000);
    wait_idle(nome);
    checks++;
    if (estado !== est_model) begin
      errors++; $display("FAIL %s_estado estado=%b required %b", nome, estado, est_model);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    set_botoes(3'b000);
    repeat (3) @(negedge clock);
    exp_q.delete();
    err_q.delete();
    est_model = 2'b00;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_botoes(3'b000);
    repeat (2) @(negedge clock);
    checks++;
    if ({estado, novo_estado, erro, ocupado, fsm_estado} !== 7'b0) begin
      errors++; $display("FAIL reset_outputs got=%b required 0000000",
                         {estado, novo_estado, erro, ocupado, fsm_estado});
    end
    do_reset();
    repeat (5) @(negedge clock);
    checks++;
    if (ocupado !== 1'b0 || estado !== 2'b00) begin
      errors++; $display("FAIL reset_idle ocupado=%b estado=%b required 0/00", ocupado, estado);
    end
  endtask

  task automatic check_latency(input logic [1:0] code, input string nome);
    for (int k = 0; k <= LAT + 1; k++) begin
      @(negedge clock);
      checks++;
      if (novo_estado !== (k == LAT)) begin
        errors++; $display("FAIL %s_latency edge=E+%0d novo=%b required %b", nome, k, novo_estado, (k == LAT));
      end
      if (k == LAT) begin
        checks++;
        if (estado !== code) begin
          errors++; $display("FAIL %s_code estado=%b required %b", nome, estado, code);
        end
      end
    end
  endtask

  task automatic test_latencia();
    int n0;
    do_reset();
    repeat (2) @(negedge clock);
    botao_01 = 1'b1;
    exp_q.push_back(2'b01);
    est_model = 2'b01;
    check_latency(2'b01, "latencia");
    n0 = n_novo;
    repeat (10) @(negedge clock);
    checks++;
    if (n_novo != n0 || ocupado !== 1'b1) begin
      errors++; $display("FAIL held_no_repeat strobes=%0d ocupado=%b required 0/1", n_novo - n0, ocupado);
    end
    botao_01 = 1'b0;
    wait_idle("latencia");
  endtask

  task automatic test_pulso_curto();
    int n0;
    do_reset();
    @(negedge clock);
    n0 = n_novo;
    botao_10 = 1'b1;
    repeat (2) @(negedge clock);
    botao_10 = 1'b0;
    repeat (15) @(negedge clock);
    checks++;
    if (n_novo != n0 || ocupado !== 1'b0 || estado !== 2'b00) begin
      errors++; $display("FAIL short_pulse strobes=%0d ocupado=%b estado=%b required 0/0/00",
                         n_novo - n0, ocupado, estado);
    end
  endtask

  task automatic test_multiplo();
    int e0;
    do_reset();
    @(negedge clock);
    e0 = n_erro;
    set_botoes(3'b101);
    expect_press(3'b101);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      checks++;
      if (erro !== (k == LAT)) begin
        errors++; $display("FAIL multi_erro edge=E+%0d erro=%b required %b", k, erro, (k == LAT));
      end
    end
    set_botoes(3'b000);
    wait_idle("multiplo");
    checks++;
    if (n_erro != e0 + 1 || estado !== 2'b00) begin
      errors++; $display("FAIL multi_summary erros=%0d estado=%b required 1/00", n_erro - e0, estado);
    end
  endtask

  task automatic test_repique();
    int n;
    do_reset();
    @(negedge clock);
    botao_00 = 1'b1;
    expect_press(3'b001);
    n = 0;
    while (!novo_estado && n < 30) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (novo_estado !== 1'b1) begin
      errors++; $display("FAIL bounce_strobe_timeout novo=%b required 1 within 30 cycles", novo_estado);
    end
    botao_00 = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock);
      checks++;
      if (ocupado !== (k < 9)) begin
        errors++; $display("FAIL bounce_ocupado edge=T+%0d ocupado=%b required %b", k, ocupado, (k < 9));
      end
      if (k == 2) botao_00 = 1'b1;
      if (k == 3) botao_00 = 1'b0;
    end
  endtask

  task automatic test_reset_meio();
    do_reset();
    @(negedge clock);
    press(3'b100, 10, "pre_reset");
    botao_01 = 1'b1;
    repeat (4) @(negedge clock);
    checks++;
    if (ocupado !== 1'b1 || fsm_estado !== 2'd1) begin
      errors++; $display("FAIL mid_filter ocupado=%b fsm=%0d required 1/1", ocupado, fsm_estado);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({estado, novo_estado, erro, ocupado} !== 5'b0) begin
      errors++; $display("FAIL async_reset got=%b required 00000", {estado, novo_estado, erro, ocupado});
    end
    exp_q.delete();
    err_q.delete();
    est_model = 2'b00;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    exp_q.push_back(2'b01);
    est_model = 2'b01;
    check_latency(2'b01, "pos_reset");
    botao_01 = 1'b0;
    wait_idle("pos_reset");
  endtask

  task automatic test_sequencia();
    do_reset();
    @(negedge clock);
    press(3'b100, 10, "seq_10");
    press(3'b010, 10, "seq_01");
    press(3'b010, 10, "seq_repete");
  endtask

  task automatic test_aleatorio();
    logic [2:0] mask;
    for (int i = 0; i < 8; i++) begin
      mask = 3'($urandom_range(1, 7));
      press(mask, $urandom_range(9, 14), "aleatorio");
    end
  endtask

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog time limit reached required completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latencia();
    test_pulso_curto();
    test_multiplo();
    test_repique();
    test_reset_meio();
    test_sequencia();
    test_aleatorio();
    repeat (5) @(negedge clock);
    checks++;
    if (exp_q.size() != 0 || err_q.size() != 0) begin
      errors++; $display("FAIL queues_drained novo_pend=%0d erro_pend=%0d required 0/0", exp_q.size(), err_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
